stage_memory: RTL and testbench
===============================

STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 clk  in  1  sole clock, all state on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 ex_valid  in  1  execute presents an instruction.
REQ-004 ex_ready  out  1  stage accepts; transfer = ex_valid & ex_ready.
REQ-005 ex_rd / ex_result_src / ex_funct3  in  5/2/3  dest reg, result select, access size.
REQ-006 ex_alu_result / ex_write_data / ex_instr_addr_plus  in  32 each  address or result, store data, PC+4.
REQ-007 ex_wr_enable / ex_mem_read / ex_mem_write  in  1 each  reg write, load, store.
REQ-008 mem_rd / mem_result_src  out  5/2  registered toward writeback.
REQ-009 mem_alu_result / mem_read_data / mem_instr_addr_plus  out  32 each  registered toward writeback.
REQ-010 mem_wr_enable  out  1  one-cycle register-write strobe to writeback.
REQ-011 dmem_req / dmem_we  out  1/1  bus request, write.
REQ-012 dmem_addr / dmem_wdata / dmem_be  out  32/32/4  word address (bits 1:0 zero), lane-replicated data, byte enables.
REQ-013 dmem_gnt / dmem_rvalid  in  1/1  request accepted, response (load data or store ack).
REQ-014 dmem_rdata  in  32  load word.
REQ-015 mem_misalign  out  1  misaligned-access pulse (see Configuration).

Function
REQ-016 FSM states IDLE, REQ, RSP; ex_ready = 1 only in IDLE.
REQ-017 IDLE, transfer, no load/store: next cycle mem_* = ex_* captured, mem_read_data = 0, mem_wr_enable = ex_wr_enable; stay IDLE (one-cycle latency, back-to-back throughput).
REQ-018 IDLE, transfer, load or store: capture ex_*, go REQ; mem_wr_enable = 0 next cycle.
REQ-019 REQ: dmem_req = 1, addr/we/wdata/be stable from captured values until dmem_gnt; on dmem_gnt go RSP.
REQ-020 RSP: dmem_req = 0; on dmem_rvalid format data, assert mem_wr_enable for exactly the next cycle with captured ex_wr_enable, go IDLE.
REQ-021 dmem_rvalid in same cycle as dmem_gnt is ignored; response counted only in RSP.
REQ-022 Load formatting by funct3, lane = addr[1:0]: 000 LB sign-extend byte, 001 LH sign-extend half at addr[1], 010 LW word, 100 LBU, 101 LHU zero-extend; others -> word.
REQ-023 Store byte enables: SB 4'b0001<<addr[1:0], SH 4'b0011<<{addr[1],1'b0}, SW 4'b1111; wdata byte/half replicated across lanes.
REQ-024 mem_wr_enable = 0 in every cycle not defined above (bubble while stalled); other mem_* hold.
REQ-025 ex_mem_read and ex_mem_write both set: treated as store.

Reset
REQ-026 rst_n low: state IDLE, all mem_* = 0, mem_wr_enable = 0, dmem_req = 0, mem_misalign = 0, immediately and asynchronously.
REQ-027 Reset mid-REQ/RSP abandons the access; a later dmem_rvalid in IDLE is ignored.
REQ-028 Release synchronous to clk; ex_ready = 1 in first cycle after release.

Configuration
REQ-029 Macro MEM_MISALIGN_TRAP_EN.
REQ-030 Defined: misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) not issued; mem_misalign = 1 for one cycle, mem_wr_enable = 0, state stays IDLE.
REQ-031 Undefined: mem_misalign tied 0; misaligned access issued with offending address bits forced to zero.

Verification
REQ-032 ALU op rd=5, result 0x1234 -> next cycle mem_rd=5, mem_alu_result=0x1234, mem_wr_enable=1.
REQ-033 LB addr 0x103, dmem_rdata 0x80FFFFFF, gnt after 2 cycles, rvalid 1 later -> mem_read_data=0xFFFFFF80, ex_ready low throughout.
REQ-034 SH addr 0x102, data 0xABCD -> dmem_be=4'b1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-035 LW addr 0x101 -> with macro: mem_misalign pulse, no dmem_req; without: dmem_addr=0x100.
REQ-036 rst_n low during RSP, then stray rvalid -> no mem_wr_enable, state IDLE, all outputs 0.

Source files
------------

// File: rtl/stage_memory.sv
// Memory stage: forwards ALU results and runs one load/store at a time on a req/gnt/rvalid data bus.
// Optional MEM_MISALIGN_TRAP_EN: drop misaligned half/word accesses and pulse mem_misalign instead.
module stage_memory #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [4:0]        ex_rd,
   input  logic [1:0]        ex_result_src,
   input  logic [2:0]        ex_funct3,
   input  logic [DATA_W-1:0] ex_alu_result,
   input  logic [DATA_W-1:0] ex_write_data,
   input  logic [DATA_W-1:0] ex_instr_addr_plus,
   input  logic              ex_wr_enable,
   input  logic              ex_mem_read,
   input  logic              ex_mem_write,
   output logic [4:0]        mem_rd,
   output logic [1:0]        mem_result_src,
   output logic [DATA_W-1:0] mem_alu_result,
   output logic [DATA_W-1:0] mem_read_data,
   output logic [DATA_W-1:0] mem_instr_addr_plus,
   output logic              mem_wr_enable,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_be,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              mem_misalign
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

   state_t            state, state_nxt;
   logic              xfer, is_mem, misal_trap, issue;
   logic              store_p0, wr_en_p0;
   logic [2:0]        funct3_p0;
   logic [1:0]        lane_p0;
   logic [DATA_W-1:0] wdata_p0;

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b001, 3'b101: return a[0];
         3'b010:         return a != 2'b00;
         default:        return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] align_lane(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         3'b001, 3'b101: return {a[1], 1'b0};
         3'b010:         return 2'b00;
         default:        return a;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [DATA_W-1:0] rdata);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = rdata[{lane, 3'b000} +: 8];
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'd0, b};
         3'b101:  return {16'd0, h};
         default: return rdata;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'b000:  return 4'b0001 << lane;
         3'b001:  return 4'b0011 << {lane[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] store_wdata(input logic [2:0] f3, input logic [DATA_W-1:0] d);
      case (f3)
         3'b000:  return {4{d[7:0]}};
         3'b001:  return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   assign xfer   = ex_valid & ex_ready;
   assign is_mem = ex_mem_read | ex_mem_write;
   assign issue  = xfer & is_mem & ~misal_trap;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misal_trap = xfer & is_mem & is_misaligned(ex_funct3, ex_alu_result[1:0]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mem_misalign <= 1'b0;
      else        mem_misalign <= misal_trap;
   end
`else
   assign misal_trap   = 1'b0;
   assign mem_misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (issue) state_nxt = REQ;
         REQ:     if (dmem_gnt) state_nxt = RSP;
         RSP:     if (dmem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ex_ready   = (state == IDLE);
      dmem_req   = (state == REQ);
      dmem_we    = dmem_req & store_p0;
      dmem_addr  = dmem_req ? {mem_alu_result[DATA_W-1:2], 2'b00} : '0;
      dmem_wdata = (dmem_req & store_p0) ? store_wdata(funct3_p0, wdata_p0) : '0;
      dmem_be    = dmem_req ? store_be(funct3_p0, lane_p0) : 4'b0000;
   end

   // ---- p0: access control captured at issue ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_p0 <= 1'b0;
         wr_en_p0 <= 1'b0;
      end else if (issue) begin
         store_p0 <= ex_mem_write;
         wr_en_p0 <= ex_wr_enable;
      end
   end

   always_ff @(posedge clk) begin
      if (issue) begin
         funct3_p0 <= ex_funct3;
         lane_p0   <= align_lane(ex_funct3, ex_alu_result[1:0]);
         wdata_p0  <= ex_write_data;
      end
   end

   // ---- writeback-facing registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_rd              <= '0;
         mem_result_src      <= '0;
         mem_alu_result      <= '0;
         mem_read_data       <= '0;
         mem_instr_addr_plus <= '0;
         mem_wr_enable       <= 1'b0;
      end else begin
         mem_wr_enable <= 1'b0;
         if (xfer && !misal_trap) begin
            mem_rd              <= ex_rd;
            mem_result_src      <= ex_result_src;
            mem_alu_result      <= ex_alu_result;
            mem_instr_addr_plus <= ex_instr_addr_plus;
            mem_wr_enable       <= ex_wr_enable & ~is_mem;
            if (!is_mem) mem_read_data <= '0;
         end
         // rvalid only counts once the grant has moved us to RSP
         if (state == RSP && dmem_rvalid) begin
            mem_wr_enable <= wr_en_p0;
            mem_read_data <= store_p0 ? '0 : load_format(funct3_p0, lane_p0, dmem_rdata);
         end
      end
   end

endmodule

// File: tb/tb_stage_memory.sv
// Directed self-checking bench for stage_memory: ALU forwarding, loads, stores, misalignment, reset.
module tb_stage_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   logic [4:0]  ex_rd = '0;
   logic [1:0]  ex_result_src = '0;
   logic [2:0]  ex_funct3 = '0;
   logic [31:0] ex_alu_result = '0, ex_write_data = '0, ex_instr_addr_plus = '0;
   logic        ex_wr_enable = 1'b0, ex_mem_read = 1'b0, ex_mem_write = 1'b0;
   logic [4:0]  mem_rd;
   logic [1:0]  mem_result_src;
   logic [31:0] mem_alu_result, mem_read_data, mem_instr_addr_plus;
   logic        mem_wr_enable, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        mem_misalign;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   stage_memory dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_rd(ex_rd), .ex_result_src(ex_result_src), .ex_funct3(ex_funct3),
      .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
      .ex_instr_addr_plus(ex_instr_addr_plus), .ex_wr_enable(ex_wr_enable),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .mem_rd(mem_rd), .mem_result_src(mem_result_src), .mem_alu_result(mem_alu_result),
      .mem_read_data(mem_read_data), .mem_instr_addr_plus(mem_instr_addr_plus),
      .mem_wr_enable(mem_wr_enable), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .mem_misalign(mem_misalign)
   );

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_wr_enable = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b expected 0", mem_wr_enable); end
      n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", dmem_req); end
      n_chk++; if (mem_rd !== 5'd0) begin n_fail++; $display("FAIL rst_rd: got %0d expected 0", mem_rd); end
      n_chk++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL rst_alu: got %h expected 0", mem_alu_result); end
      n_chk++; if (mem_misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %b expected 0", mem_misalign); end
      next_cycle();
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", ex_ready); end
   endtask

   task automatic test_alu_op();
      ex_valid = 1'b1; ex_rd = 5'd5; ex_alu_result = 32'h1234; ex_wr_enable = 1'b1;
      ex_result_src = 2'd0; ex_instr_addr_plus = 32'h44;
      next_cycle();
      clear_ex();
      n_chk++; if (mem_rd !== 5'd5) begin n_fail++; $display("FAIL alu_rd: got %0d expected 5", mem_rd); end
      n_chk++; if (mem_alu_result !== 32'h1234) begin n_fail++; $display("FAIL alu_result: got %h expected 1234", mem_alu_result); end
      n_chk++; if (mem_wr_enable !== 1'b1) begin n_fail++; $display("FAIL alu_wr_en: got %b expected 1", mem_wr_enable); end
      n_chk++; if (mem_instr_addr_plus !== 32'h44) begin n_fail++; $display("FAIL alu_pc4: got %h expected 44", mem_instr_addr_plus); end
      n_chk++; if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL alu_rdata: got %h expected 0", mem_read_data); end
      next_cycle();
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL alu_bubble: got %b expected 0", mem_wr_enable); end
      n_chk++; if (mem_rd !== 5'd5) begin n_fail++; $display("FAIL alu_hold: got %0d expected 5", mem_rd); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] rds [3] = '{5'd1, 5'd2, 5'd3};
      logic       wes [3] = '{1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         ex_valid = 1'b1; ex_rd = rds[i]; ex_wr_enable = wes[i]; ex_alu_result = 32'h100 + i;
         next_cycle();
         n_chk++; if (mem_rd !== rds[i]) begin n_fail++; $display("FAIL b2b_rd[%0d]: got %0d expected %0d", i, mem_rd, rds[i]); end
         n_chk++; if (mem_wr_enable !== wes[i]) begin n_fail++; $display("FAIL b2b_wr_en[%0d]: got %b expected %b", i, mem_wr_enable, wes[i]); end
         n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, ex_ready); end
      end
      clear_ex();
      next_cycle();
   endtask

   task automatic test_load_byte_stall();
      ex_valid = 1'b1; ex_funct3 = 3'b000; ex_alu_result = 32'h103; ex_mem_read = 1'b1;
      ex_rd = 5'd7; ex_wr_enable = 1'b1;
      next_cycle();
      clear_ex();
      for (int i = 0; i < 2; i++) begin
         n_chk++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL lb_req[%0d]: got %b expected 1", i, dmem_req); end
         n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL lb_ready_req[%0d]: got %b expected 0", i, ex_ready); end
         n_chk++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL lb_addr[%0d]: got %h expected 100", i, dmem_addr); end
         n_chk++; if (dmem_we !== 1'b0) begin n_fail++; $display("FAIL lb_we[%0d]: got %b expected 0", i, dmem_we); end
         n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL lb_stall_wr[%0d]: got %b expected 0", i, mem_wr_enable); end
         if (i == 1) begin
            dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h11111111;
         end
         next_cycle();
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL lb_rsp_req: got %b expected 0", dmem_req); end
      n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL lb_ready_rsp: got %b expected 0", ex_ready); end
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL lb_early_rvalid: got %b expected 0", mem_wr_enable); end
      next_cycle();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h80FFFFFF;
      next_cycle();
      dmem_rvalid = 1'b0;
      n_chk++; if (mem_read_data !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h expected ffffff80", mem_read_data); end
      n_chk++; if (mem_wr_enable !== 1'b1) begin n_fail++; $display("FAIL lb_wr_en: got %b expected 1", mem_wr_enable); end
      n_chk++; if (mem_rd !== 5'd7) begin n_fail++; $display("FAIL lb_rd: got %0d expected 7", mem_rd); end
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL lb_ready_done: got %b expected 1", ex_ready); end
      next_cycle();
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL lb_one_shot: got %b expected 0", mem_wr_enable); end
   endtask

   task automatic test_load_formats();
      logic [2:0]  f3s   [4] = '{3'b001, 3'b100, 3'b101, 3'b010};
      logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h100, 32'h208};
      logic [31:0] rds   [4] = '{32'h80011234, 32'h0000F100, 32'h1234FFEE, 32'hCAFEF00D};
      logic [31:0] exps  [4] = '{32'hFFFF8001, 32'h000000F1, 32'h0000FFEE, 32'hCAFEF00D};
      for (int i = 0; i < 4; i++) begin
         ex_valid = 1'b1; ex_funct3 = f3s[i]; ex_alu_result = addrs[i]; ex_mem_read = 1'b1;
         ex_wr_enable = 1'b1; ex_rd = 5'd10 + 5'(i);
         next_cycle();
         clear_ex();
         n_chk++; if (dmem_addr !== {addrs[i][31:2], 2'b00}) begin n_fail++; $display("FAIL ld_addr[%0d]: got %h expected %h", i, dmem_addr, {addrs[i][31:2], 2'b00}); end
         dmem_gnt = 1'b1;
         next_cycle();
         dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rds[i];
         next_cycle();
         dmem_rvalid = 1'b0;
         n_chk++; if (mem_read_data !== exps[i]) begin n_fail++; $display("FAIL ld_data[%0d]: got %h expected %h", i, mem_read_data, exps[i]); end
      end
   endtask

   task automatic test_stores();
      logic [2:0]  f3s   [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
      logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h200, 32'h303};
      logic [31:0] wds   [4] = '{32'h0000ABCD, 32'h1234565A, 32'h89ABCDEF, 32'h000000C3};
      logic [3:0]  bes   [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
      logic [31:0] exws  [4] = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h89ABCDEF, 32'hC3C3C3C3};
      for (int i = 0; i < 4; i++) begin
         ex_valid = 1'b1; ex_funct3 = f3s[i]; ex_alu_result = addrs[i]; ex_write_data = wds[i];
         ex_mem_write = 1'b1; ex_mem_read = (i == 3);
         next_cycle();
         clear_ex();
         n_chk++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL st_we[%0d]: got %b expected 1", i, dmem_we); end
         n_chk++; if (dmem_be !== bes[i]) begin n_fail++; $display("FAIL st_be[%0d]: got %b expected %b", i, dmem_be, bes[i]); end
         n_chk++; if (dmem_wdata !== exws[i]) begin n_fail++; $display("FAIL st_wdata[%0d]: got %h expected %h", i, dmem_wdata, exws[i]); end
         n_chk++; if (dmem_addr !== {addrs[i][31:2], 2'b00}) begin n_fail++; $display("FAIL st_addr[%0d]: got %h expected %h", i, dmem_addr, {addrs[i][31:2], 2'b00}); end
         dmem_gnt = 1'b1;
         next_cycle();
         dmem_gnt = 1'b0; dmem_rvalid = 1'b1;
         next_cycle();
         dmem_rvalid = 1'b0;
         n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL st_wr_en[%0d]: got %b expected 0", i, mem_wr_enable); end
         n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL st_done[%0d]: got %b expected 1", i, ex_ready); end
      end
   endtask

   task automatic test_misalign();
      ex_valid = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h101; ex_mem_read = 1'b1;
      ex_wr_enable = 1'b1; ex_rd = 5'd9;
      next_cycle();
      clear_ex();
`ifdef MEM_MISALIGN_TRAP_EN
      n_chk++; if (mem_misalign !== 1'b1) begin n_fail++; $display("FAIL mis_pulse: got %b expected 1", mem_misalign); end
      n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %b expected 0", dmem_req); end
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL mis_idle: got %b expected 1", ex_ready); end
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL mis_wr_en: got %b expected 0", mem_wr_enable); end
      next_cycle();
      n_chk++; if (mem_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_one_shot: got %b expected 0", mem_misalign); end
`else
      n_chk++; if (dmem_req !== 1'b1) begin n_fail++; $display("FAIL mis_req: got %b expected 1", dmem_req); end
      n_chk++; if (dmem_addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr: got %h expected 100", dmem_addr); end
      n_chk++; if (mem_misalign !== 1'b0) begin n_fail++; $display("FAIL mis_tied: got %b expected 0", mem_misalign); end
      dmem_gnt = 1'b1;
      next_cycle();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
      next_cycle();
      dmem_rvalid = 1'b0;
      n_chk++; if (mem_read_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_data: got %h expected deadbeef", mem_read_data); end
      n_chk++; if (mem_wr_enable !== 1'b1) begin n_fail++; $display("FAIL mis_wr_en: got %b expected 1", mem_wr_enable); end
`endif
   endtask

   task automatic test_reset_mid_rsp();
      ex_valid = 1'b1; ex_funct3 = 3'b010; ex_alu_result = 32'h300; ex_mem_read = 1'b1;
      ex_wr_enable = 1'b1; ex_rd = 5'd12;
      next_cycle();
      clear_ex();
      dmem_gnt = 1'b1;
      next_cycle();
      dmem_gnt = 1'b0;
      n_chk++; if (ex_ready !== 1'b0) begin n_fail++; $display("FAIL rr_in_rsp: got %b expected 0", ex_ready); end
      rst_n = 1'b0;
      #1;
      n_chk++; if (mem_rd !== 5'd0) begin n_fail++; $display("FAIL rr_async_rd: got %0d expected 0", mem_rd); end
      n_chk++; if (mem_alu_result !== 32'd0) begin n_fail++; $display("FAIL rr_async_alu: got %h expected 0", mem_alu_result); end
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rr_async_idle: got %b expected 1", ex_ready); end
      next_cycle();
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
      next_cycle();
      dmem_rvalid = 1'b0;
      n_chk++; if (mem_wr_enable !== 1'b0) begin n_fail++; $display("FAIL rr_stray_wr: got %b expected 0", mem_wr_enable); end
      n_chk++; if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL rr_stray_data: got %h expected 0", mem_read_data); end
      n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL rr_req: got %b expected 0", dmem_req); end
      n_chk++; if (ex_ready !== 1'b1) begin n_fail++; $display("FAIL rr_ready: got %b expected 1", ex_ready); end
   endtask

   initial begin
      test_reset();
      test_alu_op();
      test_back_to_back();
      test_load_byte_stall();
      test_load_formats();
      test_stores();
      test_misalign();
      test_reset_mid_rsp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
